scmp_bus_ctl: RTL and testbench
===============================

# scmp_bus_ctl

Parametrised external bus cycle controller for the SC/MP core, with configurable address width, fixed wait states, NHOLD-style cycle stretching and ENIN/ENOUT/BREQ bus-sharing arbitration. It sits between the core's microcode sequencer and the package pins. It converts one core request into one complete ADS → RD/WR → end bus cycle, and reports completion with a single-cycle `ack_o`.

## Interface
Parameters:
- `PIN_ADDR_W`, default 12: address bits driven on `addr_o`.
- `ADDR_W`, default 16: total address width. Must satisfy `PIN_ADDR_W <= ADDR_W <= PIN_ADDR_W+4`.
- `WAIT_CYCLES`, default 0: extra strobe cycles inserted on every access.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_i` in 1: cycle request. Held with `we_i`, `addr_i`, `wdata_i` and `flags_i` stable until `ack_o`.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in ADDR_W: cycle address.
- `wdata_i` in 8: write data.
- `flags_i` in 4: {H,D,I,R} status flags, placed on the data bus during ADS.
- `lock_i` in 1: retain bus ownership after the current cycle.
- `ack_o` out 1: cycle complete, one clk wide.
- `rdata_o` out 8: captured read data, valid from `ack_o` onward.
- `busy_o` out 1: high in every state except IDLE and OWN.
- `addr_o` out PIN_ADDR_W: pin address.
- `d_o` out 8: data out.
- `d_oe_o` out 1: data bus output enable.
- `d_i` in 8: data bus input.
- `ads_n_o`, `rd_n_o`, `wr_n_o` out 1: strobes, active-low.
- `hold_n_i` in 1: low stretches the strobe phase. Synchronous input.
- `breq_o` out 1: bus request.
- `enin_i` in 1: bus grant in.
- `enout_o` out 1: bus grant out, daisy chain.

## Operation
- **Reset values:** `ads_n_o`/`rd_n_o`/`wr_n_o` = 1; `ack_o`, `busy_o`, `breq_o`, `d_oe_o` = 0; `addr_o`, `d_o`, `rdata_o` = 0; state = IDLE.
- **Grant chain:** `enout_o = enin_i & ~breq_o`, combinational.
- **IDLE:** `req_i` → REQ.
- **REQ:** `breq_o` = 1. When `enin_i` = 1, latch `addr_i`, `we_i`, `wdata_i`, `flags_i` and go to ADS.
- **ADS (1 cycle):**
  - `ads_n_o` = 0, `addr_o` = `addr[PIN_ADDR_W-1:0]`, `d_oe_o` = 1.
  - `d_o` = {flags, upper address bits zero-padded to 4}.
  - Load wait counter with WAIT_CYCLES. Go to STRB.
- **STRB:**
  - `rd_n_o` = 0 for a read, `wr_n_o` = 0 for a write.
  - Write: `d_o` = wdata, `d_oe_o` = 1. Read: `d_oe_o` = 0.
  - Counter decrements each cycle while nonzero.
  - Exit when counter == 0 and `hold_n_i` == 1. A read captures `d_i` into `rdata_o` on that exit cycle. Go to END.
- **END (1 cycle):**
  - Strobes high. Address held. Write keeps `d_oe_o`/`d_o` for hold time.
  - `ack_o` = 1.
  - Go to OWN if `lock_i` = 1, else IDLE (`breq_o` drops).
- **OWN:** `breq_o` = 1, `busy_o` = 0.
  - `req_i` with `enin_i` = 1 → ADS, skipping REQ.
  - `enin_i` = 0 → REQ.
  - `req_i` = 0 and `lock_i` = 0 → IDLE.
- **Grant loss:** `enin_i` falling during ADS/STRB/END is ignored. A started cycle always completes.
- **Reset mid-cycle:** all strobes return high asynchronously and `breq_o` drops. No `ack_o` is issued.

## Timing
- Minimum read/write with `enin_i` already high, measured from `req_i` sampled in IDLE: REQ, ADS, STRB, END. `ack_o` arrives 4 cycles after `req_i`.
- From OWN the same path takes 3 cycles.
- STRB lasts `1 + WAIT_CYCLES + (cycles with hold_n_i low at or after counter zero)`.
- `hold_n_i` low while the counter is still nonzero adds no cycles.
- `rdata_o` is stable until the next read capture.
- `addr_o` holds its last value in IDLE/OWN.

## Structure
- Package `scmp_bus_pak` holds:
  - the `BUS_ST_t` enum (IDLE, REQ, ADS, STRB, END, OWN);
  - flag bit index constants `BUS_F_H/D/I/R`.
- Latches use existing `reg8` instances for data. Address and counter registers are inline.
- No sub-module. The wait counter is `$clog2(WAIT_CYCLES+1)` bits, with a minimum width of 1.

## Test plan
- **Basic read:** WAIT_CYCLES=0, `enin_i`=1, read `addr_i`=16'hA123, flags=4'b0001.
  - ADS cycle: `addr_o`=12'h123, `d_o`=8'h1A.
  - `d_i`=8'h5C in STRB gives `rdata_o`=8'h5C, `ack_o` 4 cycles after `req_i`.
- **Write with wait states:** WAIT_CYCLES=2, write 8'h3E.
  - `wr_n_o` low exactly 3 cycles, `d_o`=8'h3E through END, `d_oe_o`=0 in the following IDLE.
- **Hold stretch:** `hold_n_i` low for 4 cycles starting at the first STRB cycle, WAIT_CYCLES=0.
  - STRB lasts 5 cycles; `rdata_o` is the `d_i` sampled on the 5th.
- **Arbitration:** `enin_i`=0 for 6 cycles after `req_i`.
  - `breq_o`=1 and `enout_o`=0 throughout; ADS starts the cycle after `enin_i` rises.
  - Dropping `enin_i` during STRB does not abort the cycle.
- **Lock:** `lock_i`=1 on two back-to-back reads.
  - `breq_o` stays high, the second `ack_o` arrives 3 cycles after its `req_i`.
  - Deasserting `lock_i` returns to IDLE with `breq_o`=0 and `enout_o`=`enin_i`.
- **Reset in STRB:** assert `rst_n`=0 mid-write.
  - `wr_n_o`=1 immediately, no `ack_o`, all outputs at reset values.

Source files
------------

// File: rtl/scmp_bus_ctl_pkg.sv
// scmp_bus_pak: shared bus-cycle state encoding and status flag bit positions.
package scmp_bus_pak;
    typedef enum logic [2:0] {IDLE, REQ, ADS, STRB, END, OWN} BUS_ST_t;
    localparam int BUS_F_H = 3;
    localparam int BUS_F_D = 2;
    localparam int BUS_F_I = 1;
    localparam int BUS_F_R = 0;
endpackage

// File: rtl/reg8.sv
// reg8: 8-bit enabled data register with asynchronous active-low clear.
module reg8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/scmp_bus_ctl.sv
// scmp_bus_ctl: SC/MP external bus cycle controller (ADS -> RD/WR -> END) with
// wait states, hold stretching and ENIN/ENOUT/BREQ bus-sharing arbitration.
module scmp_bus_ctl
    import scmp_bus_pak::*;
#(
    parameter int PIN_ADDR_W  = 12,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [7:0]            wdata_i,
    input  logic [3:0]            flags_i,
    input  logic                  lock_i,
    output logic                  ack_o,
    output logic [7:0]            rdata_o,
    output logic                  busy_o,
    output logic [PIN_ADDR_W-1:0] addr_o,
    output logic [7:0]            d_o,
    output logic                  d_oe_o,
    input  logic [7:0]            d_i,
    output logic                  ads_n_o,
    output logic                  rd_n_o,
    output logic                  wr_n_o,
    input  logic                  hold_n_i,
    output logic                  breq_o,
    input  logic                  enin_i,
    output logic                  enout_o
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    BUS_ST_t           st, st_nx;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        flags_q;
    logic [7:0]        wdata_q;
    logic [CW-1:0]     cnt;
    logic              lat, strb_done, rd_cap, wr_ph;
    logic [3:0]        hi;

    assign strb_done = (cnt == '0) && hold_n_i;
    assign lat       = (st_nx == ADS);
    assign rd_cap    = (st == STRB) && !we_q && strb_done;

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = req_i ? REQ : IDLE;
            REQ:     st_nx = enin_i ? ADS : REQ;
            ADS:     st_nx = STRB;
            STRB:    st_nx = strb_done ? END : STRB;
            END:     st_nx = lock_i ? OWN : IDLE;
            OWN:     st_nx = (req_i && enin_i) ? ADS : (!req_i && !lock_i) ? IDLE : !enin_i ? REQ : OWN;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            flags_q <= '0;
            cnt     <= '0;
        end else begin
            st <= st_nx;
            if (lat) begin
                addr_q  <= addr_i;
                we_q    <= we_i;
                flags_q <= flags_i;
            end
            if (st == ADS) cnt <= CW'(WAIT_CYCLES);
            else if (st == STRB && cnt != '0) cnt <= cnt - CW'(1);
        end
    end

    reg8 u_wdata (.clk(clk), .rst_n(rst_n), .en(lat), .d(wdata_i), .q(wdata_q));
    reg8 u_rdata (.clk(clk), .rst_n(rst_n), .en(rd_cap), .d(d_i), .q(rdata_o));

    // Address bits above the pins ride on the data bus, zero-padded to a nibble.
    assign hi      = 4'(addr_q >> PIN_ADDR_W);
    assign wr_ph   = we_q && (st == STRB || st == END);
    assign ads_n_o = (st != ADS);
    assign rd_n_o  = !(st == STRB && !we_q);
    assign wr_n_o  = !(st == STRB && we_q);
    assign d_oe_o  = (st == ADS) || wr_ph;
    assign d_o     = (st == ADS) ? {flags_q[BUS_F_H], flags_q[BUS_F_D], flags_q[BUS_F_I], flags_q[BUS_F_R], hi}
                   : wr_ph ? wdata_q : 8'h00;
    assign addr_o  = addr_q[PIN_ADDR_W-1:0];
    assign ack_o   = (st == END);
    assign busy_o  = !(st == IDLE || st == OWN);
    assign breq_o  = (st != IDLE);
    assign enout_o = enin_i & ~breq_o;
endmodule

// File: tb/tb_scmp_bus_ctl.sv
// tb_scmp_bus_ctl: directed bench with ack scoreboard for two controller instances
// (no wait states and two wait states) sharing the bus-side stimulus.
module tb_scmp_bus_ctl;
    typedef struct {int cyc; logic rd; logic [7:0] dat;} exp_t;

    logic clk = 1'b0, rst_n;
    logic req0, req2, we, lock, hold_n, enin;
    logic [15:0] addr;
    logic [7:0] wdata, d_i;
    logic [3:0] flags;
    logic ack0, busy0, doe0, ads0, rd0, wr0, breq0, enout0;
    logic ack2, busy2, doe2, ads2, rd2, wr2, breq2, enout2;
    logic [7:0] rdata0, do0, rdata2, do2;
    logic [11:0] addr0, addr2;
    int cyc = 0, vec = 0, err = 0, n;
    exp_t q0[$], q2[$];
    exp_t e0, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scmp_bus_ctl #(.PIN_ADDR_W(12), .ADDR_W(16), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .flags_i(flags), .lock_i(lock), .ack_o(ack0), .rdata_o(rdata0), .busy_o(busy0),
        .addr_o(addr0), .d_o(do0), .d_oe_o(doe0), .d_i(d_i), .ads_n_o(ads0), .rd_n_o(rd0),
        .wr_n_o(wr0), .hold_n_i(hold_n), .breq_o(breq0), .enin_i(enin), .enout_o(enout0));

    scmp_bus_ctl #(.PIN_ADDR_W(12), .ADDR_W(16), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_i(req2), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .flags_i(flags), .lock_i(lock), .ack_o(ack2), .rdata_o(rdata2), .busy_o(busy2),
        .addr_o(addr2), .d_o(do2), .d_oe_o(doe2), .d_i(d_i), .ads_n_o(ads2), .rd_n_o(rd2),
        .wr_n_o(wr2), .hold_n_i(hold_n), .breq_o(breq2), .enin_i(enin), .enout_o(enout2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                vec++; err++;
                $display("FAIL sb0 unexpected ack at cycle %0d, expected none", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("sb0 ack cycle", cyc, e0.cyc);
                if (e0.rd) chk("sb0 rdata", {24'h0, rdata0}, {24'h0, e0.dat});
            end
        end
        if (ack2 === 1'b1) begin
            if (q2.size() == 0) begin
                vec++; err++;
                $display("FAIL sb2 unexpected ack at cycle %0d, expected none", cyc);
            end else begin
                e2 = q2.pop_front();
                chk("sb2 ack cycle", cyc, e2.cyc);
                if (e2.rd) chk("sb2 rdata", {24'h0, rdata2}, {24'h0, e2.dat});
            end
        end
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req2 = 1'b0; we = 1'b0; lock = 1'b0; hold_n = 1'b1; enin = 1'b1;
        addr = '0; wdata = '0; d_i = '0; flags = '0;
        #3;
        chk("rst strobes", {ads0, rd0, wr0, ads2, rd2, wr2}, 6'b111111);
        chk("rst ctl", {ack0, busy0, breq0, doe0, ack2, busy2, breq2, doe2}, 8'h00);
        chk("rst data", {addr0, do0, rdata0}, 28'h0);
        chk("rst enout", {enout0, enout2}, 2'b11);
        step;
        rst_n = 1'b1;
        step;

        // basic read, no wait states
        n = cyc; we = 1'b0; addr = 16'hA123; flags = 4'b0001; d_i = 8'h5C; req0 = 1'b1;
        q0.push_back('{n + 4, 1'b1, 8'h5C});
        step;
        chk("rd REQ breq/busy", {breq0, busy0, ads0}, 3'b111);
        step;
        chk("rd ADS strobe", {ads0, doe0}, 2'b01);
        chk("rd ADS addr", addr0, 12'h123);
        chk("rd ADS d_o", do0, 8'h1A);
        step;
        chk("rd STRB", {rd0, doe0, wr0}, 3'b001);
        step;
        chk("rd END", {ack0, rd0, rdata0}, {2'b11, 8'h5C});
        req0 = 1'b0;
        step;
        chk("rd IDLE", {busy0, breq0, addr0}, {2'b00, 12'h123});

        // write with two wait states
        n = cyc; we = 1'b1; addr = 16'h0456; wdata = 8'h3E; flags = 4'b0000; req2 = 1'b1;
        q2.push_back('{n + 6, 1'b0, 8'h00});
        step;
        step;
        chk("wr ADS", {ads2, wr2, do2}, {2'b01, 8'h00});
        for (int k = 0; k < 3; k++) begin
            step;
            chk("wr STRB", {wr2, doe2, do2}, {2'b01, 8'h3E});
        end
        step;
        chk("wr END", {wr2, ack2, doe2, do2}, {3'b111, 8'h3E});
        req2 = 1'b0;
        step;
        chk("wr IDLE oe", {doe2, busy2}, 2'b00);

        // hold stretch: hold_n low for the first four STRB cycles
        n = cyc; we = 1'b0; addr = 16'h0010; flags = 4'b1000; req0 = 1'b1;
        q0.push_back('{n + 8, 1'b1, 8'hC5});
        step;
        step;
        chk("hold ADS d_o", do0, 8'h80);
        for (int k = 1; k <= 5; k++) begin
            step;
            hold_n = (k < 5) ? 1'b0 : 1'b1;
            d_i = 8'hC0 + 8'(k);
            chk("hold STRB", {rd0, ack0}, 2'b00);
        end
        step;
        chk("hold END", {ack0, rdata0}, {1'b1, 8'hC5});
        req0 = 1'b0;
        step;

        // arbitration: grant withheld six cycles, then lost during STRB
        n = cyc; enin = 1'b0; we = 1'b0; addr = 16'h0F00; flags = 4'b0000; d_i = 8'h77; req0 = 1'b1;
        q0.push_back('{n + 9, 1'b1, 8'h77});
        for (int k = 0; k < 6; k++) begin
            step;
            chk("arb wait", {breq0, enout0, ads0}, 3'b101);
        end
        enin = 1'b1;
        chk("arb enout grant", enout0, 1'b0);
        step;
        chk("arb ADS", ads0, 1'b0);
        step;
        enin = 1'b0;
        chk("arb STRB grant lost", {rd0, enout0}, 2'b00);
        step;
        chk("arb END", ack0, 1'b1);
        req0 = 1'b0; enin = 1'b1;
        step;
        chk("arb IDLE", {breq0, enout0}, 2'b01);

        // lock: back-to-back reads keeping the bus
        n = cyc; lock = 1'b1; we = 1'b0; addr = 16'h0222; d_i = 8'h11; req0 = 1'b1;
        q0.push_back('{n + 4, 1'b1, 8'h11});
        step; step; step; step;
        req0 = 1'b0;
        step;
        chk("lock OWN", {breq0, busy0, enout0}, 3'b100);
        n = cyc; addr = 16'h0333; d_i = 8'h22; req0 = 1'b1;
        q0.push_back('{n + 3, 1'b1, 8'h22});
        step;
        chk("lock ADS from OWN", {ads0, breq0, addr0}, {2'b01, 12'h333});
        step;
        step;
        chk("lock END", {ack0, breq0}, 2'b11);
        req0 = 1'b0; lock = 1'b0;
        step;
        chk("unlock IDLE", {breq0, enout0}, 2'b01);
        enin = 1'b0;
        #1;
        chk("unlock enout follows", enout0, 1'b0);
        enin = 1'b1;
        step;

        // reset in the middle of a waited write
        we = 1'b1; addr = 16'h0ABC; wdata = 8'h5A; req2 = 1'b1;
        step; step; step;
        chk("rst-mid STRB", wr2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst-mid strobes", {ads2, rd2, wr2}, 3'b111);
        chk("rst-mid ctl", {ack2, busy2, breq2, doe2}, 4'h0);
        chk("rst-mid data", {addr2, do2, rdata2, rdata0}, 36'h0);
        req2 = 1'b0;
        step; step;
        rst_n = 1'b1;
        step; step;
        chk("post-rst idle", {busy2, breq2, ack2}, 3'b000);
        chk("sb0 drained", q0.size(), 0);
        chk("sb2 drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
